ptp_sync_sched: RTL and testbench
=================================

// Module: ptp_sync_sched
// PURPOSE
//  Periodic scheduler that sequences the PTP control FSM. Issues one-cycle sync_start
//  pulses to the PTP controller every configured interval.
//  - Master: also pulses send_sync_pkt to tx_proc.
//  - Slave: supervises round completion (status_ok / error / timeout) and keeps
//    saturating statistics plus a lock indication.
//  Sits between the ctrl register block and the PTP control FSM / tx_proc.
// PARAMETERS
//  PERIOD_W   32  width of cfg_period (idle cycles between rounds)
//  TIMEOUT_W  24  width of cfg_timeout (slave round watchdog, cycles)
//  CNT_W      16  width of statistics counters (saturating)
//  MAX_FAIL   3   consecutive failed rounds that clear sync_locked
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-low reset
//  sched_en      in   1          level; 1 = run periodic rounds
//  device_role   in   2          bit0: 1 = master, 0 = slave; latched at each round start
//  cfg_period    in   PERIOD_W   cycles spent in WAIT_PERIOD; 0 is treated as 1
//  cfg_timeout   in   TIMEOUT_W  slave round watchdog; 0 = no timeout
//  status_ok     in   1          pulse from PTP controller: slave round succeeded
//  error         in   1          pulse/level from PTP controller: round failed
//  sync_start    out  1          one-cycle pulse to PTP controller
//  send_sync_pkt out  1          one-cycle pulse to tx_proc (master rounds only)
//  sync_busy     out  1          1 while state is WAIT_DONE
//  round_done    out  1          one-cycle pulse when any slave round ends (ok, err or timeout)
//  sync_locked   out  1          slave synchronised
//  ok_cnt        out  CNT_W      successful slave rounds
//  err_cnt       out  CNT_W      rounds ended by error
//  to_cnt        out  CNT_W      rounds ended by timeout
// BEHAVIOUR
//  Reset
//   - All outputs 0, internal counters 0, state IDLE, fail_streak 0, role_q 0.
//   - Reset is honoured mid-round; no pulse is emitted after reset asserts.
//  States
//   - IDLE: sched_en=1 -> START.
//   - START: one cycle. Drive sync_start=1 and latch role_q=device_role[0].
//     role_q=1: also drive send_sync_pkt=1, then go to WAIT_PERIOD.
//     role_q=0: clear the watchdog, then go to WAIT_DONE.
//   - WAIT_DONE: watchdog increments each cycle. Priority is error > status_ok > timeout.
//     error: err_cnt++, fail_streak++.
//     status_ok: ok_cnt++, fail_streak=0, sync_locked=1.
//     timeout: fires when cfg_timeout!=0 and watchdog==cfg_timeout; to_cnt++, fail_streak++.
//     Any of these: round_done=1 for one cycle, then WAIT_PERIOD.
//   - WAIT_PERIOD: period counter counts 1..max(cfg_period,1), then START.
//  sched_en=0 in any state
//   - Next edge goes to IDLE. No further sync_start pulses.
//   - sync_locked and fail_streak are cleared; statistics are held.
//  Locking and statistics
//   - fail_streak saturates at MAX_FAIL. Reaching MAX_FAIL clears sync_locked.
//   - A master round (role_q=1) clears sync_locked.
//   - All statistics saturate at all-ones, with no wrap.
//  Timing and registering
//   - Round-start latency: the edge that samples sched_en=1 in IDLE enters START;
//     sync_start is high for the following cycle.
//   - All outputs are registered. Pulses are exactly one cycle wide.
//   - Inputs status_ok/error are ignored outside WAIT_DONE.
//   - cfg_* is sampled live each cycle; a change takes effect on the next compare.
// TESTING
//  - Slave, period=10, timeout=100, status_ok 5 cycles after sync_start ->
//    ok_cnt=1, sync_locked=1, round_done once, next sync_start 11 cycles after round_done.
//  - Slave, timeout=20, no response -> round_done exactly 20 cycles after sync_start;
//    to_cnt=1. After 3 such rounds: sync_locked=0, to_cnt=3.
//  - Slave, status_ok and error in the same cycle -> err_cnt=1, ok_cnt=0, fail_streak=1.
//  - Master, period=4 -> sync_start and send_sync_pkt coincide and repeat every 5 cycles;
//    ok_cnt/err_cnt/to_cnt remain 0.
//  - sched_en dropped in WAIT_DONE, and reset asserted mid-WAIT_PERIOD -> state IDLE,
//    no sync_start, sync_locked=0; stats held for sched_en, zeroed for reset.
//  - Force ok_cnt to 16'hFFFE, run 3 OK rounds -> ok_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/ptp_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : ptp_sync_sched
// Brief    : Periodic round scheduler for the PTP control FSM. Emits one-cycle
//            sync_start pulses (plus send_sync_pkt on master rounds), watches
//            slave rounds for ok / error / timeout, keeps saturating round
//            statistics and a lock indication.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_sync_sched #(
  parameter int PERIOD_W  = 32,
  parameter int TIMEOUT_W = 24,
  parameter int CNT_W     = 16,
  parameter int MAX_FAIL  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sched_en,
  input  logic [1:0]           device_role,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 status_ok,
  input  logic                 error,
  output logic                 sync_start,
  output logic                 send_sync_pkt,
  output logic                 sync_busy,
  output logic                 round_done,
  output logic                 sync_locked,
  output logic [CNT_W-1:0]     ok_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     to_cnt
);

  localparam int STREAK_W = $clog2(MAX_FAIL + 1);
  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_FAIL);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_START       = 2'd1,
    S_WAIT_DONE   = 2'd2,
    S_WAIT_PERIOD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  role_q, role_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic [PERIOD_W-1:0]   pc_q, pc_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  sync_start_q, sync_start_d;
  logic                  send_q, send_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  locked_q, locked_d;
  logic [CNT_W-1:0]      ok_q, ok_d;
  logic [CNT_W-1:0]      err_q, err_d;
  logic [CNT_W-1:0]      to_q, to_d;

  logic [PERIOD_W-1:0]   period_eff;
  logic [TIMEOUT_W-1:0]  wd_inc;
  logic                  period_hit;
  logic                  timeout_hit;
  logic                  begin_round;
  logic                  round_end;
  logic                  round_fail;
  logic                  unused_role_bit;

  // Only bit0 of device_role carries meaning.
  assign unused_role_bit = device_role[1];

  // A zero period still spends one cycle waiting.
  assign period_eff = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
  assign period_hit = (pc_q >= period_eff);

  // The watchdog counts cycles since sync_start and saturates instead of
  // wrapping; the compare uses the value it reaches at this edge, and >= lets
  // a timeout lowered on the fly still end the round.
  assign wd_inc      = (&wd_q) ? wd_q : wd_q + TIMEOUT_W'(1);
  assign timeout_hit = (cfg_timeout != '0) && (wd_inc >= cfg_timeout);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, statistics and registered-output computation.
  always_comb begin
    state_d      = state_q;
    role_d       = role_q;
    wd_d         = wd_q;
    pc_d         = pc_q;
    streak_d     = streak_q;
    locked_d     = locked_q;
    ok_d         = ok_q;
    err_d        = err_q;
    to_d         = to_q;
    sync_start_d = 1'b0;
    send_d       = 1'b0;
    done_d       = 1'b0;
    begin_round  = 1'b0;
    round_end    = 1'b0;
    round_fail   = 1'b0;

    if (!sched_en) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
      streak_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin_round = 1'b1;
        S_START: begin
          if (role_q) begin
            state_d = S_WAIT_PERIOD;
            pc_d    = PERIOD_W'(1);
          end else begin
            // The START cycle is the first watched cycle of the round.
            state_d = S_WAIT_DONE;
            wd_d    = TIMEOUT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          wd_d = wd_inc;
          if (error) begin
            err_d      = sat_inc(err_q);
            round_fail = 1'b1;
            round_end  = 1'b1;
          end else if (status_ok) begin
            ok_d      = sat_inc(ok_q);
            streak_d  = '0;
            locked_d  = 1'b1;
            round_end = 1'b1;
          end else if (timeout_hit) begin
            to_d       = sat_inc(to_q);
            round_fail = 1'b1;
            round_end  = 1'b1;
          end
        end
        S_WAIT_PERIOD: begin
          if (period_hit) begin
            begin_round = 1'b1;
          end else begin
            pc_d = pc_q + PERIOD_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (round_fail) begin
        streak_d = (streak_q >= MAX_STREAK) ? MAX_STREAK : streak_q + STREAK_W'(1);
        if (streak_d == MAX_STREAK) begin
          locked_d = 1'b0;
        end
      end

      // The round_done cycle sits ahead of the period count (counter value 0).
      if (round_end) begin
        state_d = S_WAIT_PERIOD;
        pc_d    = '0;
        done_d  = 1'b1;
      end

      if (begin_round) begin
        state_d      = S_START;
        sync_start_d = 1'b1;
        role_d       = device_role[0];
        send_d       = device_role[0];
        if (device_role[0]) begin
          locked_d = 1'b0;
        end
      end
    end

    busy_d = (state_d == S_WAIT_DONE);
  end

  // State, counters and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      role_q       <= 1'b0;
      wd_q         <= '0;
      pc_q         <= '0;
      streak_q     <= '0;
      sync_start_q <= 1'b0;
      send_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      ok_q         <= '0;
      err_q        <= '0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      role_q       <= role_d;
      wd_q         <= wd_d;
      pc_q         <= pc_d;
      streak_q     <= streak_d;
      sync_start_q <= sync_start_d;
      send_q       <= send_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      locked_q     <= locked_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      to_q         <= to_d;
    end
  end

  assign sync_start    = sync_start_q;
  assign send_sync_pkt = send_q;
  assign sync_busy     = busy_q;
  assign round_done    = done_q;
  assign sync_locked   = locked_q;
  assign ok_cnt        = ok_q;
  assign err_cnt       = err_q;
  assign to_cnt        = to_q;

endmodule
`default_nettype wire

// File: tb/tb_ptp_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_sync_sched
// Brief    : Self-checking bench for ptp_sync_sched: table of single-round
//            scenarios, hand sequences for lock/disable/reset/saturation, and
//            a randomized run against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptp_sync_sched;

  localparam int MAX_FAIL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sched_en = 1'b0;
  logic [1:0]  device_role = 2'b00;
  logic [31:0] cfg_period = 32'd0;
  logic [23:0] cfg_timeout = 24'd0;
  logic        status_ok = 1'b0;
  logic        error = 1'b0;

  logic        sync_start, send_sync_pkt, sync_busy, round_done, sync_locked;
  logic [15:0] ok_cnt, err_cnt, to_cnt;
  logic        s_sync_start, s_send, s_busy, s_done, s_locked;
  logic [1:0]  s_ok, s_err, s_to;

  ptp_sync_sched u_dut (
    .clk(clk), .reset(reset), .sched_en(sched_en), .device_role(device_role),
    .cfg_period(cfg_period), .cfg_timeout(cfg_timeout), .status_ok(status_ok), .error(error),
    .sync_start(sync_start), .send_sync_pkt(send_sync_pkt), .sync_busy(sync_busy),
    .round_done(round_done), .sync_locked(sync_locked),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .to_cnt(to_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a few rounds.
  ptp_sync_sched #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .sched_en(sched_en), .device_role(device_role),
    .cfg_period(cfg_period), .cfg_timeout(cfg_timeout), .status_ok(status_ok), .error(error),
    .sync_start(s_sync_start), .send_sync_pkt(s_send), .sync_busy(s_busy),
    .round_done(s_done), .sync_locked(s_locked),
    .ok_cnt(s_ok), .err_cnt(s_err), .to_cnt(s_to)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: rounds described by timestamps (cycle numbers).
  bit m_run, m_wait;
  int m_round_t, m_deadline, m_next_start;
  int m_ok, m_err, m_to, m_streak;
  bit e_start, e_send, e_busy, e_done, e_locked;

  function automatic longint sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_round_t = 0; m_deadline = 0; m_next_start = 0;
    m_ok = 0; m_err = 0; m_to = 0; m_streak = 0;
    e_start = 0; e_send = 0; e_busy = 0; e_done = 0; e_locked = 0;
  endtask

  // A round starting at cycle n. A slave round can end no earlier than n+2
  // because the waiting phase begins the cycle after sync_start.
  task automatic model_begin(input int n, input int p);
    e_start = 1;
    e_send = device_role[0];
    m_round_t = n;
    if (device_role[0]) begin
      e_locked = 0;
      m_wait = 0;
      m_next_start = n + 1 + p;
    end else begin
      m_wait = 1;
      m_deadline = (cfg_timeout == 0) ? 0 : n + ((cfg_timeout < 2) ? 2 : int'(cfg_timeout));
    end
  endtask

  // Consumes the inputs of cycle cyc, produces the expected outputs of cyc+1.
  task automatic model_edge();
    int n; int p; bit fin; bit fail;
    n = cyc + 1;
    p = (cfg_period == 0) ? 1 : int'(cfg_period);
    fin = 0; fail = 0;
    e_start = 0; e_send = 0; e_done = 0;
    if (!sched_en) begin
      m_run = 0; m_wait = 0; e_locked = 0; m_streak = 0;
    end else if (!m_run) begin
      m_run = 1;
      model_begin(n, p);
    end else if (m_wait) begin
      if (cyc > m_round_t) begin
        if (error) begin m_err++; fail = 1; fin = 1; end
        else if (status_ok) begin m_ok++; m_streak = 0; e_locked = 1; fin = 1; end
        else if (m_deadline != 0 && n == m_deadline) begin m_to++; fail = 1; fin = 1; end
        if (fail) begin
          if (m_streak < MAX_FAIL) m_streak++;
          if (m_streak == MAX_FAIL) e_locked = 0;
        end
        if (fin) begin
          m_wait = 0;
          e_done = 1;
          m_next_start = n + p + 1;
        end
      end
    end else if (n == m_next_start) begin
      model_begin(n, p);
    end
    e_busy = m_wait && !e_start;
  endtask

  task automatic check_outputs();
    chk("sync_start", sync_start, e_start);
    chk("send_sync_pkt", send_sync_pkt, e_send);
    chk("sync_busy", sync_busy, e_busy);
    chk("round_done", round_done, e_done);
    chk("sync_locked", sync_locked, e_locked);
    chk("ok_cnt", ok_cnt, sat(m_ok, 65535));
    chk("err_cnt", err_cnt, sat(m_err, 65535));
    chk("to_cnt", to_cnt, sat(m_to, 65535));
    chk("narrow sync_start", s_sync_start, e_start);
    chk("narrow ok_cnt", s_ok, sat(m_ok, 3));
    chk("narrow err_cnt", s_err, sat(m_err, 3));
    chk("narrow to_cnt", s_to, sat(m_to, 3));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge(); else model_reset();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    reset = 0; sched_en = 0; status_ok = 0; error = 0;
    model_reset();
    #1;
    check_outputs();
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge.
  task automatic async_reset_now();
    #2;
    reset = 0;
    #1;
    model_reset();
    check_outputs();
  endtask

  task automatic wait_event(input string name, input int limit, input bit want_done);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = want_done ? round_done : sync_busy;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no event within %0d cycles", name, limit);
    end
  endtask

  typedef struct {
    bit master; int period; int timeout; int ok_at; int err_at;
    int exp_done; int exp_next; int exp_ok; int exp_err; int exp_to; bit exp_locked;
  } vec_t;

  vec_t tv[9];
  int done_rel, next_rel, starts;

  initial begin
    // role, period, timeout, ok@, err@ | done, next start, ok, err, to, locked
    tv[0] = '{0, 10, 100,  5, -1,  6, 17, 1, 0, 0, 1};
    tv[1] = '{0, 10,  20, -1, -1, 20, 31, 0, 0, 1, 0};
    tv[2] = '{0,  3,  50,  4,  4,  5,  9, 0, 1, 0, 0};
    tv[3] = '{1,  4,   7, -1, -1, -1,  5, 0, 0, 0, 0};
    tv[4] = '{0,  0,   2, -1, -1,  2,  4, 0, 0, 1, 0};
    tv[5] = '{0,  1,   0, -1,  3,  4,  6, 0, 1, 0, 0};
    tv[6] = '{0,  2,   0,  1, -1,  2,  5, 1, 0, 0, 1};
    tv[7] = '{0,  5,   3,  2, -1,  3,  9, 1, 0, 0, 1};
    tv[8] = '{0,  2,   6,  0, -1,  6,  9, 0, 0, 1, 0};

    for (int i = 0; i < 9; i++) begin
      apply_reset();
      device_role = {1'b0, tv[i].master};
      cfg_period  = tv[i].period;
      cfg_timeout = tv[i].timeout;
      sched_en = 1;
      tick();
      chk("first sync_start", sync_start, 1);
      chk("first send_sync_pkt", send_sync_pkt, tv[i].master);
      done_rel = -1; next_rel = -1;
      for (int rel = 0; rel < 200 && next_rel < 0; rel++) begin
        status_ok = (rel == tv[i].ok_at);
        error     = (rel == tv[i].err_at);
        tick();
        if (round_done && done_rel < 0) done_rel = rel + 1;
        if (sync_start) next_rel = rel + 1;
      end
      status_ok = 0; error = 0;
      chk("round_done latency", done_rel, tv[i].exp_done);
      chk("next sync_start latency", next_rel, tv[i].exp_next);
      chk("table ok_cnt", ok_cnt, tv[i].exp_ok);
      chk("table err_cnt", err_cnt, tv[i].exp_err);
      chk("table to_cnt", to_cnt, tv[i].exp_to);
      chk("table sync_locked", sync_locked, tv[i].exp_locked);
    end

    // Lock on an ok round, then lose it after MAX_FAIL timeouts.
    apply_reset();
    device_role = 0; cfg_period = 10; cfg_timeout = 100; status_ok = 1; sched_en = 1;
    wait_event("lock round", 50, 1);
    status_ok = 0;
    cfg_timeout = 20;
    chk("locked after ok", sync_locked, 1);
    for (int r = 1; r <= 3; r++) begin
      wait_event("timeout round", 100, 1);
      chk("streak to_cnt", to_cnt, r);
      chk("streak sync_locked", sync_locked, (r < MAX_FAIL));
    end

    // sched_en dropped while waiting for the slave round.
    apply_reset();
    cfg_period = 3; cfg_timeout = 0; status_ok = 1; sched_en = 1;
    wait_event("ok round", 20, 1);
    status_ok = 0;
    wait_event("busy", 20, 0);
    sched_en = 0;
    tick();
    chk("disable busy", sync_busy, 0);
    chk("disable locked", sync_locked, 0);
    chk("disable ok_cnt held", ok_cnt, 1);
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sync_start) starts++;
    end
    chk("no start while disabled", starts, 0);

    // Reset in the middle of a master WAIT_PERIOD.
    device_role = 1; cfg_period = 30; sched_en = 1;
    for (int k = 0; k < 6; k++) tick();
    async_reset_now();
    chk("reset ok_cnt cleared", ok_cnt, 0);
    starts = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sync_start) starts++;
    end
    chk("no start in reset", starts, 0);
    reset = 1;
    tick();
    chk("restart after reset", sync_start, 1);

    // Saturation of the narrow counters; wide counters keep counting.
    apply_reset();
    device_role = 0; cfg_period = 1; cfg_timeout = 0; status_ok = 1; sched_en = 1;
    for (int k = 0; k < 40; k++) tick();
    chk("narrow ok saturates", s_ok, 3);
    chk("wide ok_cnt", ok_cnt, m_ok);
    status_ok = 0; error = 1;
    for (int k = 0; k < 40; k++) tick();
    chk("narrow err saturates", s_err, 3);
    chk("locked lost on errors", sync_locked, 0);
    error = 0;

    // Randomized run; cfg only changes together with sched_en=0.
    apply_reset();
    cfg_period = 5; cfg_timeout = 10;
    for (int k = 0; k < 4000; k++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        async_reset_now();
        tick();
        reset = 1;
      end
      if (r < 20) begin
        sched_en = 0;
        cfg_period = $urandom_range(0, 12);
        cfg_timeout = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(2, 25));
      end else begin
        sched_en = 1;
      end
      device_role = 2'($urandom_range(0, 3));
      status_ok = ($urandom_range(0, 15) == 0);
      error = ($urandom_range(0, 23) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
